// File: rtl/instr_fetch.sv
// instr_fetch: PC holder and instruction fetch stage for the single-cycle MIPS core.
// Fetches one word per instruction over a ready handshake, holds it until the core
// reports ex_done, then loads the next PC (sequential, j/jal, jr or taken branch).
// Optional feature macro: IFETCH_ALIGN_CHECK_EN -- a misaligned next PC (only reachable
// through jr) parks the stage in a terminal FAULT state instead of being truncated.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        ex_done,
  input  logic [1:0]  jump,
  input  logic        branch,
  input  logic        branch_taken,
  input  logic [31:0] branch_imm,
  input  logic [31:0] jr_addr,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {FETCH, HOLD, FAULT} state_t;

  state_t      state;
  logic [31:0] next_pc;

  assign pc_plus4    = pc + 32'd4;
  assign imem_addr   = pc;
  // Gated with rst_n so the request drops the moment reset asserts.
  assign imem_req    = rst_n && (state == FETCH);
  assign instr_valid = (state == HOLD);

`ifdef IFETCH_ALIGN_CHECK_EN
  assign fetch_fault = (state == FAULT);
`else
  assign fetch_fault = 1'b0;
`endif

  // Next PC selection: jumps override branches; jump==2'b11 behaves as sequential.
  always_comb begin
    next_pc = pc_plus4;
    case (jump)
      2'b01:   next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
      2'b10:   next_pc = jr_addr;
      default: if (branch && branch_taken) next_pc = pc_plus4 + (branch_imm << 2);
    endcase
  end

  // Fetch/hold sequencer; pc and instr only move on the handshake edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      pc    <= RESET_PC;
      instr <= 32'h0;
    end else begin
      case (state)
        FETCH: if (imem_ready) begin
          instr <= imem_rdata;
          state <= HOLD;
        end
        HOLD: if (ex_done) begin
`ifdef IFETCH_ALIGN_CHECK_EN
          pc    <= next_pc;
          state <= (next_pc[1:0] != 2'b00) ? FAULT : FETCH;
`else
          pc    <= next_pc & ~32'h3;
          state <= FETCH;
`endif
        end
        FAULT:   state <= FAULT;
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: an abstract fetch/execute model checked every
// cycle, plus literal expectations on the key fetch addresses.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        ex_done;
  logic [1:0]  jump;
  logic        branch;
  logic        branch_taken;
  logic [31:0] branch_imm;
  logic [31:0] jr_addr;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4),
    .ex_done(ex_done), .jump(jump), .branch(branch),
    .branch_taken(branch_taken), .branch_imm(branch_imm),
    .jr_addr(jr_addr), .fetch_fault(fetch_fault)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 = waiting for memory, 1 = instruction held, 2 = faulted
  int          m_phase;
  logic [31:0] m_pc;
  logic [31:0] m_instr;

  function automatic logic [31:0] target(input logic [31:0] cur, input logic [31:0] word,
                                         input logic [1:0] j, input logic b, input logic t,
                                         input logic [31:0] imm, input logic [31:0] ra);
    logic [31:0] seq;
    seq = cur + 32'd4;
    if (j == 2'd1)   return (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) * 4);
    if (j == 2'd2)   return ra;
    if (b && t)      return seq + imm * 4;
    return seq;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] t;
    if (!rst_n) begin
      m_phase <= 0;
      m_pc    <= 32'h0;
      m_instr <= 32'h0;
    end else if (m_phase == 0 && imem_ready) begin
      m_instr <= imem_rdata;
      m_phase <= 1;
    end else if (m_phase == 1 && ex_done) begin
      t = target(m_pc, m_instr, jump, branch, branch_taken, branch_imm, jr_addr);
`ifdef IFETCH_ALIGN_CHECK_EN
      m_pc    <= t;
      m_phase <= (t % 4 != 0) ? 2 : 0;
`else
      m_pc    <= t - (t % 4);
      m_phase <= 0;
`endif
    end
  end

  // Compare every cycle on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_req", {31'b0, imem_req}, 32'h0);
      chk("rst_valid", {31'b0, instr_valid}, 32'h0);
      chk("rst_pc", pc, 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_fault", {31'b0, fetch_fault}, 32'h0);
    end else begin
      chk("req", {31'b0, imem_req}, {31'b0, m_phase == 0});
      chk("valid", {31'b0, instr_valid}, {31'b0, m_phase == 1});
      chk("fault", {31'b0, fetch_fault}, {31'b0, m_phase == 2});
      chk("pc", pc, m_pc);
      chk("pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("instr", instr, m_instr);
      if (m_phase == 0) chk("imem_addr", imem_addr, m_pc);
    end
  end

  // ---------------- stimulus (all tasks start/end at posedge+1) ----------------
  task automatic fetch(input int dly, input logic [31:0] word, input logic noise);
    imem_rdata = word;
    imem_ready = 1'b0;
    ex_done    = noise;
    repeat (dly) @(posedge clk) #1;
    ex_done    = 1'b0;
    imem_ready = 1'b1;
    @(posedge clk) #1;
    imem_ready = 1'b0;
  endtask

  task automatic exec(input logic [1:0] j, input logic b, input logic t,
                      input logic [31:0] imm, input logic [31:0] ra);
    jump = j; branch = b; branch_taken = t; branch_imm = imm; jr_addr = ra;
    ex_done = 1'b1;
    @(posedge clk) #1;
    ex_done = 1'b0; jump = 2'd0; branch = 1'b0; branch_taken = 1'b0;
    branch_imm = 32'h0; jr_addr = 32'h0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0; ex_done = 1'b0;
    jump = 2'd0; branch = 1'b0; branch_taken = 1'b0; branch_imm = 32'h0; jr_addr = 32'h0;
    repeat (2) @(posedge clk) #1;
    chk("lit_rst_req", {31'b0, imem_req}, 32'h0);
    rst_n = 1'b1;
    #1 chk("lit_req_after_release", {31'b0, imem_req}, 32'h1);

    // Sequential stream at full rate
    for (int i = 0; i < 4; i++) begin
      chk("lit_seq_addr", imem_addr, i * 4);
      fetch(0, 32'h2000_0000 + i, 1'b0);
      exec(2'd0, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    chk("lit_pc_10", imem_addr, 32'h10);

    // Slow memory: 3 wait cycles, ex_done noise while fetching is ignored
    fetch(3, 32'hCAFE_0010, 1'b1);
    chk("lit_slow_instr", instr, 32'hCAFE_0010);
    chk("lit_slow_pc", pc, 32'h10);

    exec(2'd2, 1'b0, 1'b0, 32'h0, 32'h100);
    fetch(0, 32'h0800_0040, 1'b0);
    exec(2'd1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("lit_j_target", imem_addr, 32'h100);
    fetch(0, 32'h0000_0008, 1'b0);
    exec(2'd2, 1'b0, 1'b0, 32'h0, 32'h2000);
    chk("lit_jr_target", imem_addr, 32'h2000);

    // Branch taken backwards from 0x200
    fetch(0, 32'h0000_0008, 1'b0);
    exec(2'd2, 1'b0, 1'b0, 32'h0, 32'h200);
    fetch(0, 32'h1000_FFFE, 1'b0);
    exec(2'd0, 1'b1, 1'b1, 32'hFFFF_FFFE, 32'h0);
    chk("lit_br_taken", imem_addr, 32'h1FC);
    chk("lit_model_br", m_pc, 32'h1FC);

    // Branch not taken
    fetch(0, 32'h0000_0008, 1'b0);
    exec(2'd2, 1'b0, 1'b0, 32'h0, 32'h200);
    fetch(0, 32'h1000_FFFE, 1'b0);
    exec(2'd0, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0);
    chk("lit_br_not_taken", imem_addr, 32'h204);

    // Jump beats a taken branch
    fetch(0, 32'h0800_0040, 1'b0);
    exec(2'd1, 1'b1, 1'b1, 32'h5, 32'h0);
    chk("lit_jump_wins", imem_addr, 32'h100);

    // Stalled HOLD with stray imem_ready, then jump==11 behaves sequentially
    fetch(0, 32'h0800_0999, 1'b0);
    imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk) #1;
    imem_ready = 1'b0;
    chk("lit_hold_instr", instr, 32'h0800_0999);
    exec(2'd3, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("lit_jump11_seq", imem_addr, 32'h104);

    // Wrap at top of address space
    fetch(0, 32'h0000_0008, 1'b0);
    exec(2'd2, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFC);
    fetch(0, 32'h0, 1'b0);
    exec(2'd0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("lit_wrap", imem_addr, 32'h0);

    // Reset mid-FETCH: request drops at once, late ready answers RESET_PC
    exec(2'd0, 1'b0, 1'b0, 32'h0, 32'h0); // ignored in FETCH
    fetch(0, 32'h0000_0008, 1'b0);
    exec(2'd2, 1'b0, 1'b0, 32'h0, 32'h300);
    #2 rst_n = 1'b0;
    #1 chk("lit_rst_mid_fetch_req", {31'b0, imem_req}, 32'h0);
    @(posedge clk) #1;
    imem_ready = 1'b1; imem_rdata = 32'h1234_5678;
    rst_n = 1'b1;
    chk("lit_restart_addr", imem_addr, 32'h0);
    @(posedge clk) #1;
    imem_ready = 1'b0;
    chk("lit_late_ready_instr", instr, 32'h1234_5678);
    chk("lit_late_ready_pc", pc, 32'h0);
    exec(2'd0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset mid-HOLD
    fetch(0, 32'h0000_0001, 1'b0);
    #2 rst_n = 1'b0;
    @(posedge clk) #1;
    rst_n = 1'b1;
    chk("lit_rst_mid_hold", imem_addr, 32'h0);

    // Misaligned jr target
    fetch(0, 32'h0000_0008, 1'b0);
    exec(2'd2, 1'b0, 1'b0, 32'h0, 32'h1002);
`ifdef IFETCH_ALIGN_CHECK_EN
    chk("lit_fault", {31'b0, fetch_fault}, 32'h1);
    chk("lit_fault_pc", pc, 32'h1002);
    imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) exec(2'd0, 1'b0, 1'b0, 32'h0, 32'h0);
    imem_ready = 1'b0;
    chk("lit_fault_no_req", {31'b0, imem_req}, 32'h0);
`else
    chk("lit_no_fault", {31'b0, fetch_fault}, 32'h0);
    chk("lit_aligned_addr", imem_addr, 32'h1000);
    fetch(1, 32'h0000_0002, 1'b0);
    exec(2'd0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("lit_after_align", imem_addr, 32'h1004);
`endif

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
